// File: rtl/vga_frame_scan_reader_if.sv
// Frame-buffer read port: the scan reader drives address/strobe, the RAM
// answers with 24-bit {R,G,B} a fixed number of cycles later.

interface vga_frame_scan_reader_if;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [23:0] rd_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/vga_frame_scan_reader.sv
// Raster-to-frame-buffer read path at 160x120 virtual resolution, with sync/blank
// realigned to the read latency and a frame-boundary front/back buffer swap.

module vga_frame_scan_reader #(
  parameter int RD_LATENCY = 2,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int VIRT_W     = 160
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            active_pixels,
  input  logic [9:0]                      x,
  input  logic [9:0]                      y,
  input  logic                            hs_in,
  input  logic                            vs_in,
  input  logic                            blank_n_in,
  input  logic                            frame_done,
  input  logic                            swap_req,
  output logic                            swap_ack,
  output logic                            front_sel,
  output logic                            back_sel,
  vga_frame_scan_reader_if.master         mem,
  output logic [7:0]                      vga_r,
  output logic [7:0]                      vga_g,
  output logic [7:0]                      vga_b,
  output logic                            vga_hs,
  output logic                            vga_vs,
  output logic                            vga_blank_n
);

  // The row multiply is hard-wired as (vy<<7)+(vy<<5); other geometries need a new adder.
  if (VIRT_W != 160 || VIRT_W * 4 != H_ACTIVE) begin : g_bad_geometry
    $error("vga_frame_scan_reader: VIRT_W must be 160 and equal H_ACTIVE/4");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("vga_frame_scan_reader: RD_LATENCY must be 1..4");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  typedef enum logic {
    S_IDLE,
    S_ACK
  } swap_state_e;

  // ---------------------------------------------------------------------------
  // Stage A: coordinate to word address
  // ---------------------------------------------------------------------------
  logic        in_range;
  logic [14:0] vx;
  logic [14:0] vy;
  logic [14:0] word;
  logic        rd_en_d,   rd_en_q;
  logic [15:0] rd_addr_d, rd_addr_q;
  logic        front_sel_d, front_sel_q;

  // NOTE: every signal written in an always_comb gets a value before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    in_range  = active_pixels && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));
    vx        = {7'd0, x[9:2]};
    vy        = {7'd0, y[9:2]};
    word      = (vy << 7) + (vy << 5) + vx;
    rd_en_d   = in_range;
    rd_addr_d = in_range ? {front_sel_q, word} : 16'd0;
  end

  // ---------------------------------------------------------------------------
  // Valid and sync delay lines
  // ---------------------------------------------------------------------------
  logic  [RD_LATENCY-1:0] vld_d, vld_q;
  sync_t [RD_LATENCY:0]   sync_d, sync_q;

  always_comb begin
    vld_d[0] = rd_en_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    sync_d[0] = '{hs: hs_in, vs: vs_in, blank_n: blank_n_in};
    for (int i = 1; i <= RD_LATENCY; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  // NOTE: the delay lines are plain flops, not RAM, so they reset to the
  // inactive sync/blank pattern and a mid-frame reset blanks the DAC at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= 16'd0;
      vld_q     <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
        sync_q[i] <= SYNC_IDLE;
      end
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_q     <= vld_d;
      sync_q    <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage B: the RAM output is already a register, so the colour mux sits
  // behind the registered valid; this keeps the total latency at 1+RD_LATENCY.
  // ---------------------------------------------------------------------------
  logic pix_valid;

  always_comb begin
    pix_valid   = vld_q[RD_LATENCY-1];
    vga_r       = pix_valid ? mem.rd_data[23:16] : 8'd0;
    vga_g       = pix_valid ? mem.rd_data[15:8]  : 8'd0;
    vga_b       = pix_valid ? mem.rd_data[7:0]   : 8'd0;
    vga_hs      = sync_q[RD_LATENCY].hs;
    vga_vs      = sync_q[RD_LATENCY].vs;
    vga_blank_n = sync_q[RD_LATENCY].blank_n;
  end

  assign mem.rd_en   = rd_en_q;
  assign mem.rd_addr = rd_addr_q;

  // ---------------------------------------------------------------------------
  // Double-buffer swap: only a request present on the frame_done cycle counts,
  // so a visible frame is always read from one buffer.
  // ---------------------------------------------------------------------------
  swap_state_e state_d, state_q;

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_ack    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_done && swap_req) begin
          front_sel_d = ~front_sel_q;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        swap_ack = 1'b1;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      front_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
    end
  end

  assign front_sel = front_sel_q;
  assign back_sel  = ~front_sel_q;

endmodule

// File: tb/tb_vga_frame_scan_reader.sv
// Scoreboard bench for vga_frame_scan_reader with a synchronous RAM model on
// the read port.

module tb_vga_frame_scan_reader;

  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active_pixels = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic       hs_in = 1'b1;
  logic       vs_in = 1'b1;
  logic       blank_n_in = 1'b0;
  logic       frame_done = 1'b0;
  logic       swap_req = 1'b0;
  logic       swap_ack, front_sel, back_sel;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n;

  always #5 clk = ~clk;

  vga_frame_scan_reader_if mem_if ();

  vga_frame_scan_reader #(.RD_LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .active_pixels(active_pixels),
    .x            (x),
    .y            (y),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .blank_n_in   (blank_n_in),
    .frame_done   (frame_done),
    .swap_req     (swap_req),
    .swap_ack     (swap_ack),
    .front_sel    (front_sel),
    .back_sel     (back_sel),
    .mem          (mem_if.master),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_blank_n  (vga_blank_n)
  );

  // RAM contents; 323 holds the reference colour, everything else a pattern
  // whose red byte is never zero.
  function automatic logic [23:0] mem_word(input logic [15:0] a);
    if (a == 16'd323) return 24'hFF8001;
    return {1'b1, a[14:8], a[7:0] ^ 8'hA5, a[15:8] ^ 8'h5A};
  endfunction

  // Synchronous RAM: data for a strobe seen at an edge is valid L-1 edges later,
  // i.e. L cycles after the strobe appears; idle slots return all ones.
  logic [23:0] mem_pipe [L];
  always @(posedge clk) begin
    mem_pipe[0] <= mem_if.rd_en ? mem_word(mem_if.rd_addr) : 24'hFFFFFF;
    for (int i = 1; i < L; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_if.rd_data = mem_pipe[L-1];

  typedef struct {
    int          due;
    logic        rd_en;
    logic [15:0] addr;
    logic        fs;
    logic        ack;
  } exp_a_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        bn;
  } exp_b_t;

  exp_a_t qa[$];
  exp_b_t qb[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     ack_cnt = 0;
  logic   fs_m = 1'b0;
  logic   ack_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_compare();
    exp_a_t ea;
    exp_b_t eb;
    while (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      check("rd_en",     32'(mem_if.rd_en),   32'(ea.rd_en));
      check("rd_addr",   32'(mem_if.rd_addr), 32'(ea.addr));
      check("front_sel", 32'(front_sel),      32'(ea.fs));
      check("back_sel",  32'(back_sel),       32'(!ea.fs));
      check("swap_ack",  32'(swap_ack),       32'(ea.ack));
    end
    while (qb.size() > 0 && qb[0].due <= cyc) begin
      eb = qb.pop_front();
      check("rgb",     32'({vga_r, vga_g, vga_b}), 32'(eb.rgb));
      check("vga_hs",  32'(vga_hs),      32'(eb.hs));
      check("vga_vs",  32'(vga_vs),      32'(eb.vs));
      check("blank_n", 32'(vga_blank_n), 32'(eb.bn));
    end
    if (swap_ack) ack_cnt++;
  endtask

  // Drive one cycle of stimulus, queue what it must produce, then clock.
  task automatic step(input logic act, input int xi, input int yi, input logic hs,
                      input logic vs, input logic bn, input logic fd, input logic sr);
    logic        in_r;
    int          word;
    logic [15:0] addr;
    logic        fs_nx;
    logic        ack_nx;
    active_pixels = act;
    x             = 10'(xi);
    y             = 10'(yi);
    hs_in         = hs;
    vs_in         = vs;
    blank_n_in    = bn;
    frame_done    = fd;
    swap_req      = sr;
    in_r = act && (xi < 640) && (yi < 480);
    word = (yi / 4) * 160 + (xi / 4);
    addr = in_r ? 16'(int'(fs_m) * 32768 + word) : 16'd0;
    fs_nx  = fs_m;
    ack_nx = 1'b0;
    if (!ack_m && fd && sr) begin
      fs_nx  = !fs_m;
      ack_nx = 1'b1;
    end
    qa.push_back('{cyc + 1, in_r, addr, fs_nx, ack_nx});
    qb.push_back('{cyc + 1 + L, in_r ? mem_word(addr) : 24'd0, hs, vs, bn});
    fs_m  = fs_nx;
    ack_m = ack_nx;
    @(posedge clk);
    cyc++;
    #1;
    sb_compare();
  endtask

  task automatic pix(input int xi, input int yi);
    step(1'b1, xi, yi, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_idle_inputs();
    active_pixels = 1'b0;
    x = '0;
    y = '0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    blank_n_in = 1'b0;
    frame_done = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},   32'(mem_if.rd_en),   32'd0);
    check({tag, "_rd_addr"}, 32'(mem_if.rd_addr), 32'd0);
    check({tag, "_rgb"},     32'({vga_r, vga_g, vga_b}), 32'd0);
    check({tag, "_hs"},      32'(vga_hs),      32'd1);
    check({tag, "_vs"},      32'(vga_vs),      32'd1);
    check({tag, "_blank_n"}, 32'(vga_blank_n), 32'd0);
    check({tag, "_front"},   32'(front_sel),   32'd0);
    check({tag, "_back"},    32'(back_sel),    32'd1);
    check({tag, "_ack"},     32'(swap_ack),    32'd0);
  endtask

  initial begin
    drive_idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) idle();

    // Address and data alignment, with an hs pulse riding along.
    step(1'b1, 13, 9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("addr_323", 32'(mem_if.rd_addr), 32'd323);
    check("rden_323", 32'(mem_if.rd_en), 32'd1);
    repeat (L) idle();
    check("vga_r_ff", 32'(vga_r), 32'h0FF);
    check("vga_g_80", 32'(vga_g), 32'h080);
    check("vga_b_01", 32'(vga_b), 32'h001);
    check("hs_pulse", 32'(vga_hs), 32'd0);
    pix(639, 479);
    check("addr_max", 32'(mem_if.rd_addr), 32'd19199);

    // Blanking and out-of-range glitches.
    step(1'b0, 13, 9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("inactive_no_rd", 32'(mem_if.rd_en), 32'd0);
    pix(700, 10);
    check("x700_no_rd", 32'(mem_if.rd_en), 32'd0);
    pix(10, 480);
    check("y480_no_rd", 32'(mem_if.rd_en), 32'd0);
    repeat (L) idle();
    check("y480_black", 32'({vga_r, vga_g, vga_b}), 32'd0);

    // Mixed raster traffic.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 719), $urandom_range(0, 519),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b0, 1'b0);
    end

    // Swap handshake.
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("swap_front", 32'(front_sel), 32'd1);
    check("swap_back",  32'(back_sel),  32'd0);
    check("swap_ack_hi", 32'(swap_ack), 32'd1);
    idle();
    check("swap_ack_lo", 32'(swap_ack), 32'd0);
    pix(13, 9);
    check("addr_back", 32'(mem_if.rd_addr), 32'd33091);

    // Request withdrawn before frame end: no swap.
    ack_cnt = 0;
    repeat (2) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) idle();
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    check("noswap_acks",  32'(ack_cnt),   32'd0);
    check("noswap_front", 32'(front_sel), 32'd1);

    // Request held across three frame ends: three swaps.
    ack_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      repeat (4) step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    idle();
    check("three_acks",  32'(ack_cnt),   32'd3);
    check("three_front", 32'(front_sel), 32'd0);

    // Back-to-back frame_done: the one landing in ACK is ignored.
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle();
    check("fd_in_ack_front", 32'(front_sel), 32'd1);

    // Reset in the middle of a visible run on buffer 1.
    for (int i = 0; i < 6; i++) pix(100 + 4 * i, 200);
    check("pre_rst_rgb_nz", 32'({vga_r, vga_g, vga_b} != 24'd0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    drive_idle_inputs();
    qa.delete();
    qb.delete();
    fs_m  = 1'b0;
    ack_m = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    pix(13, 9);
    check("post_rst_addr", 32'(mem_if.rd_addr), 32'd323);
    repeat (L + 1) idle();

    // Drain whatever is still in flight, bounded.
    repeat (L + 2) begin
      @(posedge clk);
      cyc++;
      #1;
      sb_compare();
    end
    check("drain_qa", 32'(qa.size()), 32'd0);
    check("drain_qb", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_frame_scan_reader.md
# vga_frame_scan_reader

Read-side counterpart of the frame-buffer write path. The VGA frame driver supplies raster coordinates. This block converts each coordinate to a frame-buffer word address at 160x120 virtual resolution (4x4 pixel blocks) and issues the memory read. It then returns 24-bit RGB to the DAC pins, with sync and blank delayed to match the read latency. It also owns double-buffer selection: game FSMs write the back buffer, and a swap handshake flips front and back at frame boundaries.

## Interface
- RD_LATENCY, 2: cycles from rd_en/rd_addr registered to rd_data valid (1..4)
- H_ACTIVE, 640: visible width in screen pixels
- V_ACTIVE, 480: visible height in screen pixels
- VIRT_W, 160: virtual pixels per row (H_ACTIVE/4)
- clk  in  1  system clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-high reset
- active_pixels  in  1  raster inside visible area
- x  in  10  current screen column
- y  in  10  current screen row
- hs_in, vs_in  in  1  raw syncs from timing generator, active-low
- blank_n_in  in  1  raw blank, active-low
- frame_done  in  1  one-cycle pulse at end of frame
- swap_req  in  1  level; writer requests front/back exchange
- swap_ack  out  1  one-cycle pulse: swap performed
- front_sel  out  1  buffer currently scanned out
- back_sel  out  1  ~front_sel; buffer writers must target
- rd_en  out  1  memory read strobe
- rd_addr  out  16  {front_sel, 15-bit word address}
- rd_data  in  24  memory read data, {R,G,B}
- vga_r, vga_g, vga_b  out  8  pixel colour
- vga_hs, vga_vs, vga_blank_n  out  1  delayed syncs/blank

## Operation
- Stage A (address), registered every cycle:
  - in_range = active_pixels & x<H_ACTIVE & y<V_ACTIVE.
  - vx = x>>2, vy = y>>2.
  - word = vy*160 + vx, computed as (vy<<7)+(vy<<5)+vx in 15 bits; maximum 19199, no overflow.
  - rd_en = in_range; rd_addr = {front_sel, word} when in_range, else 16'd0.
- Memory: external synchronous RAM returns rd_data RD_LATENCY cycles after stage A.
- Stage B (output), registered:
  - Pixel valid = in_range delayed by RD_LATENCY.
  - vga_r/g/b = rd_data[23:16]/[15:8]/[7:0] when valid, else 0.
- hs_in, vs_in, blank_n_in pass through a shift register with total depth 1+RD_LATENCY, so they stay aligned with the RGB.
- Swap FSM, states IDLE, ACK:
  - IDLE: if frame_done & swap_req, toggle front_sel and go to ACK. Otherwise stay.
  - ACK: swap_ack=1 for exactly this cycle, then IDLE.
- swap_req low at the frame_done cycle means no swap, even if it was high earlier in the frame.
- swap_req held high across multiple frames causes one swap per frame. Requesters drop swap_req on swap_ack.
- A frame_done during ACK is ignored. This cannot occur in practice because frames are far longer than 2 cycles.
- front_sel changes only in the cycle after frame_done, so a visible frame never mixes buffers.

## Timing
- Reset (async assert, sync-release behaviour irrelevant):
  - rd_en=0, rd_addr=0.
  - vga_r/g/b=0, vga_blank_n=0, vga_hs=1, vga_vs=1.
  - All delay-line stages load these inactive values.
  - front_sel=0, back_sel=1, swap_ack=0, FSM=IDLE.
- Latency from x/y/active_pixels/syncs sampled to RGB/sync outputs: 1+RD_LATENCY clocks (3 at default).
- Reset mid-frame: outputs go inactive immediately. front_sel returns to 0 even if a swap had happened.
- frame_done and swap_req rising in the same cycle: the swap occurs.
- Coordinates x>=640 or y>=480 with active_pixels=1 (driver glitch) are treated as out of range: no read, black output.

## Test plan
- Read address: x=13, y=9, active, front_sel=0 -> rd_en=1, rd_addr=323 one cycle later; x=639, y=479 -> rd_addr=19199.
- Data alignment: feed rd_data=24'hFF8001 exactly RD_LATENCY after the request -> vga_r=FF, vga_g=80, vga_b=01 at cycle 1+RD_LATENCY. hs_in pulse appears on vga_hs at the same offset.
- Blanking: active_pixels=0 with rd_data=24'hFFFFFF -> rd_en=0, RGB=0. Also x=700, active=1 -> rd_en=0.
- Swap handshake: swap_req=1, then pulse frame_done -> next cycle front_sel=1, back_sel=0, and swap_ack is high for one cycle. A subsequent read at x=13, y=9 gives rd_addr=0x8000|323=33091.
- No swap: swap_req pulsed high then low before frame_done -> front_sel unchanged, no swap_ack. Holding swap_req=1 for 3 frame_done pulses -> front_sel toggles 3 times, 3 acks.
- Reset mid-stream: assert rst while front_sel=1 and RGB is non-zero -> all outputs at reset values in the same cycle, front_sel=0.
